// File: rtl/mac_relu_unit.sv
// Three-stage signed multiply-accumulate with a ReLU view of the accumulator.
// Define MAC_SAT_EN for saturating arithmetic and the sticky sat_flag output.
module mac_relu_unit #(
   parameter int DATA_W = 32,
   parameter int ACC_W  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     enable,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic signed [ACC_W-1:0]  acc,
   output logic signed [ACC_W-1:0]  relu_acc,
   output logic                     busy
`ifdef MAC_SAT_EN
   ,
   output logic                     sat_flag
`endif
);

   localparam int PW = 2 * DATA_W;
   localparam int EW = (PW > ACC_W) ? PW : ACC_W;
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic signed [DATA_W-1:0] a_p1_q, a_p1_d, b_p1_q, b_p1_d;
   logic                     vld_p1_q, vld_p1_d;
   logic signed [ACC_W-1:0]  prod_p2_q, prod_p2_d;
   logic                     vld_p2_q, vld_p2_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic                     load_p1;

`ifdef MAC_SAT_EN
   logic signed [PW-1:0] prod_full;
   logic                 sat_p2_q, sat_p2_d;
   logic                 sat_flag_q, sat_flag_d;
   logic                 prod_ovf, sum_ovf;

   function automatic logic signed [ACC_W-1:0] sat_prod(
      input  logic signed [PW-1:0] p,
      output logic                 ovf
   );
      logic signed [EW-1:0] pe, hi, lo;
      pe  = EW'(p);
      hi  = EW'(ACC_MAX);
      lo  = EW'(ACC_MIN);
      ovf = (pe > hi) || (pe < lo);
      if (pe > hi) return ACC_MAX;
      else if (pe < lo) return ACC_MIN;
      else return pe[ACC_W-1:0];
   endfunction

   // One extra sum bit exposes signed overflow as a mismatch of the top two bits.
   function automatic logic signed [ACC_W-1:0] sat_add(
      input  logic signed [ACC_W-1:0] x,
      input  logic signed [ACC_W-1:0] y,
      output logic                    ovf
   );
      logic signed [ACC_W:0] s;
      s   = (ACC_W+1)'(x) + (ACC_W+1)'(y);
      ovf = s[ACC_W] ^ s[ACC_W-1];
      if (ovf) return s[ACC_W] ? ACC_MIN : ACC_MAX;
      else return s[ACC_W-1:0];
   endfunction
`else
   function automatic logic signed [ACC_W-1:0] wrap_mul(
      input logic signed [DATA_W-1:0] x,
      input logic signed [DATA_W-1:0] y
   );
      return ACC_W'(x) * ACC_W'(y);
   endfunction
`endif

   always_comb begin
      // stage 1: operand capture, held while idle
      load_p1  = enable & ~clr;
      vld_p1_d = load_p1;
      a_p1_d   = load_p1 ? a : a_p1_q;
      b_p1_d   = load_p1 ? b : b_p1_q;
      // stage 2: product
      vld_p2_d = vld_p1_q & ~clr;
`ifdef MAC_SAT_EN
      prod_ovf  = 1'b0;
      sum_ovf   = 1'b0;
      prod_full = a_p1_q * b_p1_q;
      prod_p2_d = sat_prod(prod_full, prod_ovf);
      sat_p2_d  = prod_ovf;
      // stage 3: saturating accumulate
      acc_d      = acc_q;
      sat_flag_d = sat_flag_q;
      if (clr) begin
         acc_d      = '0;
         sat_flag_d = 1'b0;
      end else if (vld_p2_q) begin
         acc_d      = sat_add(acc_q, prod_p2_q, sum_ovf);
         sat_flag_d = sat_flag_q | sat_p2_q | sum_ovf;
      end
`else
      prod_p2_d = wrap_mul(a_p1_q, b_p1_q);
      // stage 3: wrapping accumulate
      acc_d = acc_q;
      if (clr) acc_d = '0;
      else if (vld_p2_q) acc_d = acc_q + prod_p2_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_p1_q    <= '0;
         b_p1_q    <= '0;
         vld_p1_q  <= 1'b0;
         prod_p2_q <= '0;
         vld_p2_q  <= 1'b0;
         acc_q     <= '0;
`ifdef MAC_SAT_EN
         sat_p2_q   <= 1'b0;
         sat_flag_q <= 1'b0;
`endif
      end else begin
         a_p1_q    <= a_p1_d;
         b_p1_q    <= b_p1_d;
         vld_p1_q  <= vld_p1_d;
         prod_p2_q <= prod_p2_d;
         vld_p2_q  <= vld_p2_d;
         acc_q     <= acc_d;
`ifdef MAC_SAT_EN
         sat_p2_q   <= sat_p2_d;
         sat_flag_q <= sat_flag_d;
`endif
      end
   end

   assign acc      = acc_q;
   assign relu_acc = acc_q[ACC_W-1] ? '0 : acc_q;
   assign busy     = vld_p1_q | vld_p2_q;
`ifdef MAC_SAT_EN
   assign sat_flag = sat_flag_q;
`endif

endmodule

// File: tb/tb_mac_relu_unit.sv
// Directed bench for mac_relu_unit with hand-computed accumulator values.
// Expectations follow MAC_SAT_EN when the bench is built with it defined.
module tb_mac_relu_unit;

   logic               clk = 1'b0;
   logic               rst, clr, enable;
   logic signed [31:0] a, b;
   logic signed [31:0] acc, relu_acc;
   logic               busy;
`ifdef MAC_SAT_EN
   logic               sat_flag;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   mac_relu_unit #(.DATA_W(32), .ACC_W(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .enable   (enable),
      .a        (a),
      .b        (b),
      .acc      (acc),
      .relu_acc (relu_acc),
      .busy     (busy)
`ifdef MAC_SAT_EN
      ,
      .sat_flag (sat_flag)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic term(input int ta, input int tb_v);
      enable = 1'b1;
      a      = ta;
      b      = tb_v;
      tick();
      enable = 1'b0;
   endtask

   task automatic idle(input int n);
      enable = 1'b0;
      repeat (n) tick();
   endtask

   task automatic clear();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; enable = 1'b0; a = '0; b = '0;
      tick();
      tick();
      check("reset_acc", acc, 32'd0);
      check("reset_relu", relu_acc, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd1 - 32'd1);
      rst = 1'b0;
      tick();

      // 3x3 taps, positive result
      clear();
      term(10, -1); term(20, -1); term(30, -1);
      term(40, 0);  term(50, 0);  term(60, 0);
      term(70, 1);  term(80, 1);  term(90, 1);
      check("taps_busy_inflight", {31'd0, busy}, 32'd1);
      idle(1);
      check("taps_acc_partial", acc, 32'd90);
      check("taps_busy_drain", {31'd0, busy}, 32'd1);
      idle(1);
      check("taps_acc", acc, 32'd180);
      check("taps_relu", relu_acc, 32'd180);
      check("taps_busy_done", {31'd0, busy}, 32'd0);
      idle(4);
      check("taps_hold", acc, 32'd180);

      // 3x3 taps, negative result
      clear();
      term(10, 1);  term(20, 1);  term(30, 1);
      term(40, 0);  term(50, 0);  term(60, 0);
      term(70, -1); term(80, -1); term(90, -1);
      idle(2);
      check("neg_acc", acc, 32'hFFFFFF4C);
      check("neg_relu", relu_acc, 32'd0);
      check("neg_busy", {31'd0, busy}, 32'd0);

      // bubbles between terms
      clear();
      term(3, 4); idle(1); term(5, 6); idle(2); term(-2, 7);
      idle(2);
      check("bubble_acc", acc, 32'd28);
      check("bubble_relu", relu_acc, 32'd28);

      // clear while terms are in flight, with a concurrent enabled term
      clear();
      term(100, 1); term(100, 1);
      clr = 1'b1; enable = 1'b1; a = 7; b = 7;
      tick();
      clr = 1'b0; enable = 1'b0;
      check("clr_acc", acc, 32'd0);
      check("clr_busy", {31'd0, busy}, 32'd0);
      idle(2);
      check("clr_no_leak", acc, 32'd0);
      term(5, 5);
      idle(2);
      check("clr_then_term", acc, 32'd25);

      // overflow
      clear();
      term(32'h7FFFFFFF, 1); term(1, 1);
      idle(2);
`ifdef MAC_SAT_EN
      check("ovf_acc", acc, 32'h7FFFFFFF);
      check("ovf_relu", relu_acc, 32'h7FFFFFFF);
      check("ovf_flag", {31'd0, sat_flag}, 32'd1);
      clear();
      check("ovf_flag_cleared", {31'd0, sat_flag}, 32'd0);
`else
      check("ovf_acc", acc, 32'h80000000);
      check("ovf_relu", relu_acc, 32'd0);
`endif

      // reset during a stream
      clear();
      term(2, 3); term(4, 5); term(6, 7);
      check("pre_rst_acc", acc, 32'd6);
      rst = 1'b1; enable = 1'b1; a = 8; b = 9;
      tick();
      rst = 1'b0; enable = 1'b0;
      check("rst_acc", acc, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_relu", relu_acc, 32'd0);
      idle(3);
      check("rst_no_leak", acc, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
